// File: rtl/merge_queue_pkg.sv
// merge_queue_pkg
// Shared types and default sizing for the two-lane merge queue.
//   lane_t          : lane identifier, used for the presented word's origin
//                     and for the round-robin last-served memory.
//   DEF_D_WIDTH     : default data word width.
//   DEF_DEPTH       : default entries per lane FIFO (power of two, >= 2).
package merge_queue_pkg;

    typedef enum logic {
        LANE_A = 1'b0,
        LANE_B = 1'b1
    } lane_t;

    localparam int DEF_D_WIDTH = 6;
    localparam int DEF_DEPTH   = 4;

endpackage : merge_queue_pkg

// File: rtl/lane_fifo.sv
// lane_fifo
// Single-lane show-ahead FIFO used for each producer of merge_queue.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   wr     : write strobe (ignored while full)
//   wdata  : write data
//   rd     : read strobe, advances the head (ignored while empty)
//   rdata  : current head word (valid whenever empty = 0)
//   count  : number of words held, 0..DEPTH
//   full   : count == DEPTH
//   empty  : count == 0
module lane_fifo
    import merge_queue_pkg::*;
#(
    parameter  int D_WIDTH = DEF_D_WIDTH,
    parameter  int DEPTH   = DEF_DEPTH,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LC_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               rd,
    output logic [D_WIDTH-1:0] rdata,
    output logic [LC_W-1:0]    count,
    output logic               full,
    output logic               empty
);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [LC_W-1:0]    count_reg;

    logic wr_ok;
    logic rd_ok;

    // Full/empty come from the count, so pointer equality is never ambiguous.
    assign full  = (count_reg == LC_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    assign count = count_reg;
    assign rdata = mem[rd_ptr_reg];

    // Storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + LC_W'(1);
                2'b01:   count_reg <= count_reg - LC_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : lane_fifo

// File: rtl/merge_queue.sv
// merge_queue
// Two-producer, one-consumer merge queue. Each lane pushes into a private
// show-ahead FIFO; a round-robin arbiter presents one head word at a time.
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   up_data_a, push_a   : lane A write data / strobe
//   full_a              : lane A FIFO holds DEPTH entries
//   up_data_b, push_b   : lane B write data / strobe
//   full_b              : lane B FIFO holds DEPTH entries
//   down_data           : presented word (0 when nothing is presented)
//   down_valid          : down_data is valid
//   down_src            : origin lane of the presented word (0 = A, 1 = B)
//   pop                 : consume the presented word
//   qsize               : total words held, including the presented one
//   ovf_a, ovf_b        : sticky, a push was dropped on a full lane
module merge_queue
    import merge_queue_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = $clog2(2 * DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data_a,
    input  logic               push_a,
    output logic               full_a,
    input  logic [D_WIDTH-1:0] up_data_b,
    input  logic               push_b,
    output logic               full_b,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    output logic               down_src,
    input  logic               pop,
    output logic [CNT_W-1:0]   qsize,
    output logic               ovf_a,
    output logic               ovf_b
);

    localparam int LC_W = $clog2(DEPTH + 1);

    logic [D_WIDTH-1:0] rdata_a, rdata_b;
    logic [LC_W-1:0]    count_a, count_b;
    logic               empty_a, empty_b;
    logic               wr_a, wr_b;
    logic               rd_a, rd_b;

    logic  down_valid_reg, down_valid_next;
    lane_t down_src_reg,   down_src_next;
    lane_t last_reg,       last_next;
    logic  ovf_a_reg, ovf_b_reg;

    logic pop_acc;
    logic ne_a_next, ne_b_next;

    // ------------------------------------------------------------------
    // Lane FIFOs
    // ------------------------------------------------------------------
    // Writes are qualified by the pre-edge full flag: a pop on the same
    // edge does not make room for a push to a full lane.
    assign wr_a    = push_a && !full_a;
    assign wr_b    = push_b && !full_b;
    assign pop_acc = pop && down_valid_reg;
    assign rd_a    = pop_acc && (down_src_reg == LANE_A);
    assign rd_b    = pop_acc && (down_src_reg == LANE_B);

    lane_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_a),
        .wdata (up_data_a),
        .rd    (rd_a),
        .rdata (rdata_a),
        .count (count_a),
        .full  (full_a),
        .empty (empty_a)
    );

    lane_fifo #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_b),
        .wdata (up_data_b),
        .rd    (rd_b),
        .rdata (rdata_b),
        .count (count_b),
        .full  (full_b),
        .empty (empty_b)
    );

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Post-edge non-emptiness of each lane: a push always leaves it
    // non-empty; otherwise it stays non-empty unless its last word is popped.
    assign ne_a_next = wr_a || (!empty_a && !(rd_a && (count_a == LC_W'(1))));
    assign ne_b_next = wr_b || (!empty_b && !(rd_b && (count_b == LC_W'(1))));

    always_comb begin
        down_valid_next = down_valid_reg;
        down_src_next   = down_src_reg;
        last_next       = pop_acc ? down_src_reg : last_reg;

        // The presented word is locked until it is popped; a new choice is
        // made only when nothing is presented or the current word leaves.
        if (!down_valid_reg || pop_acc) begin
            down_valid_next = ne_a_next || ne_b_next;
            if (ne_a_next && ne_b_next) begin
                down_src_next = (last_next == LANE_A) ? LANE_B : LANE_A;
            end else if (ne_b_next) begin
                down_src_next = LANE_B;
            end else begin
                down_src_next = LANE_A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            down_valid_reg <= 1'b0;
            down_src_reg   <= LANE_A;
            last_reg       <= LANE_B;   // A wins the first tie
            ovf_a_reg      <= 1'b0;
            ovf_b_reg      <= 1'b0;
        end else begin
            down_valid_reg <= down_valid_next;
            down_src_reg   <= down_src_next;
            last_reg       <= last_next;
            if (push_a && full_a) begin
                ovf_a_reg <= 1'b1;
            end
            if (push_b && full_b) begin
                ovf_b_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    // Gated by down_valid so stale FIFO storage never shows after reset.
    assign down_data  = !down_valid_reg          ? '0      :
                        (down_src_reg == LANE_B) ? rdata_b : rdata_a;
    assign down_valid = down_valid_reg;
    assign down_src   = down_src_reg;
    assign qsize      = CNT_W'(count_a) + CNT_W'(count_b);
    assign ovf_a      = ovf_a_reg;
    assign ovf_b      = ovf_b_reg;

endmodule : merge_queue

// File: tb/tb_merge_queue.sv
// tb_merge_queue
// Scoreboard bench for merge_queue: expected words are queued as stimulus
// is driven and compared against the presented word at each accepted pop.
module tb_merge_queue;

    localparam int D_WIDTH = 6;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(2 * DEPTH + 1);

    logic               clk;
    logic               rst;
    logic [D_WIDTH-1:0] up_data_a;
    logic               push_a;
    logic               full_a;
    logic [D_WIDTH-1:0] up_data_b;
    logic               push_b;
    logic               full_b;
    logic [D_WIDTH-1:0] down_data;
    logic               down_valid;
    logic               down_src;
    logic               pop;
    logic [CNT_W-1:0]   qsize;
    logic               ovf_a;
    logic               ovf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entry: {src, data}
    logic [D_WIDTH:0] sb[$];

    merge_queue #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data_a  (up_data_a),
        .push_a     (push_a),
        .full_a     (full_a),
        .up_data_b  (up_data_b),
        .push_b     (push_b),
        .full_b     (full_b),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_src   (down_src),
        .pop        (pop),
        .qsize      (qsize),
        .ovf_a      (ovf_a),
        .ovf_b      (ovf_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic expect_word(input logic src, input logic [D_WIDTH-1:0] data);
        sb.push_back({src, data});
    endtask

    // One clock cycle of stimulus. Called #1 after an edge; returns #1 after
    // the next edge. An accepted pop is checked against the scoreboard head.
    task automatic cycle(input logic pa, input logic [D_WIDTH-1:0] da,
                         input logic pb, input logic [D_WIDTH-1:0] db,
                         input logic pp);
        logic [D_WIDTH:0] exp_w;
        push_a    = pa;
        up_data_a = da;
        push_b    = pb;
        up_data_b = db;
        pop       = pp;
        if (pp && down_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_w = sb.pop_front();
                check("pop_data", int'(down_data), int'(exp_w[D_WIDTH-1:0]));
                check("pop_src", int'(down_src), int'(exp_w[D_WIDTH]));
            end
        end
        @(posedge clk);
        #1;
        push_a = 1'b0;
        push_b = 1'b0;
        pop    = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, int'(down_valid), 0);
        check({tag, "_data"},  int'(down_data),  0);
        check({tag, "_src"},   int'(down_src),   0);
        check({tag, "_qsize"}, int'(qsize),      0);
        check({tag, "_full"},  int'({full_a, full_b}), 0);
        check({tag, "_ovf"},   int'({ovf_a, ovf_b}),   0);
    endtask

    initial begin
        rst       = 1'b0;
        push_a    = 1'b0;
        push_b    = 1'b0;
        pop       = 1'b0;
        up_data_a = '0;
        up_data_b = '0;

        // Reset state
        #12;
        check_idle("rst0");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream: outputs clear asynchronously
        for (int i = 0; i < 3; i++) cycle(1'b1, D_WIDTH'(i + 1), 1'b0, '0, 1'b0);
        check("pre_rst_qsize", int'(qsize), 3);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        #2 rst = 1'b1;
        cycle(1'b1, 6'h05, 1'b0, '0, 1'b0);
        expect_word(1'b0, 6'h05);
        check("post_rst_valid", int'(down_valid), 1);
        check("post_rst_data",  int'(down_data), 'h05);
        check("post_rst_qsize", int'(qsize), 1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("post_rst_empty", int'(qsize), 0);

        // Tie fairness: A first after reset, then alternate
        do_reset();
        cycle(1'b1, 6'h11, 1'b1, 6'h22, 1'b0);
        cycle(1'b1, 6'h12, 1'b1, 6'h23, 1'b0);
        expect_word(1'b0, 6'h11);
        expect_word(1'b1, 6'h22);
        expect_word(1'b0, 6'h12);
        expect_word(1'b1, 6'h23);
        for (int k = 0; k < 4; k++) begin
            check("tie_qsize", int'(qsize), 4 - k);
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
        end
        check("tie_qsize_end", int'(qsize), 0);
        check("tie_valid_end", int'(down_valid), 0);

        // Lock: presented A word holds while B arrives
        cycle(1'b1, 6'h0A, 1'b0, '0, 1'b0);
        expect_word(1'b0, 6'h0A);
        cycle(1'b0, '0, 1'b1, 6'h0B, 1'b0);
        expect_word(1'b1, 6'h0B);
        for (int k = 0; k < 3; k++) begin
            check("lock_data", int'(down_data), 'h0A);
            check("lock_src",  int'(down_src), 0);
            if (k < 2) cycle(1'b0, '0, 1'b0, '0, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("lock_next_data", int'(down_data), 'h0B);
        check("lock_next_src",  int'(down_src), 1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);

        // Full / overflow on lane A
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) check("full_before_4th", int'(full_a), 0);
            cycle(1'b1, D_WIDTH'(i), 1'b0, '0, 1'b0);
            expect_word(1'b0, D_WIDTH'(i));
        end
        check("full_after_4th", int'(full_a), 1);
        check("ovf_before", int'(ovf_a), 0);
        cycle(1'b1, 6'h05, 1'b0, '0, 1'b0);
        check("ovf_a_set", int'(ovf_a), 1);
        check("ovf_qsize", int'(qsize), 4);
        cycle(1'b1, 6'h06, 1'b0, '0, 1'b1);
        check("pushpop_full_a", int'(full_a), 0);
        check("pushpop_qsize", int'(qsize), 3);
        check("ovf_a_sticky", int'(ovf_a), 1);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("full_qsize_end", int'(qsize), 0);

        // Wrap-around on lane B
        do_reset();
        cycle(1'b0, '0, 1'b1, 6'h30, 1'b0);
        expect_word(1'b1, 6'h30);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b0, '0, 1'b1, D_WIDTH'(8'h30 + i), 1'b1);
            expect_word(1'b1, D_WIDTH'(8'h30 + i));
            check("wrap_qsize", int'(qsize), 1);
        end
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("wrap_qsize_end", int'(qsize), 0);
        check("wrap_ovf_b", int'(ovf_b), 0);

        // Pop on empty
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            check("empty_pop_valid", int'(down_valid), 0);
            check("empty_pop_qsize", int'(qsize), 0);
        end
        cycle(1'b0, '0, 1'b1, 6'h3F, 1'b0);
        expect_word(1'b1, 6'h3F);
        check("late_push_valid", int'(down_valid), 1);
        check("late_push_data",  int'(down_data), 'h3F);
        check("late_push_src",   int'(down_src), 1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_merge_queue
